// File: rtl/song_byte_receiver.sv
// ============================================================================
// song_byte_receiver
//
// Receive end of the BrickBreaker song byte stream. Bytes arrive on a
// valid/ready byte interface and land in a small FIFO. Software drains the
// FIFO through a 4 x 32-bit AXI4-Lite register window. A read of DATA pops
// one byte.
//
//   0x0 CTRL    (RW)  bit0 ENABLE, bit1 FLUSH (self-clearing, reads 0),
//                     bits[15:8] THRESH
//   0x4 STATUS  (R/W1C) [8:0] count, 16 empty, 17 full, 18 STALL (sticky)
//   0x8 DATA    (R)   {1, 23'b0, head byte} and pop, or 0 when empty
//   0xC RXCOUNT (R)   running total of accepted bytes (wraps)
//
// Ports:
//   s00_axi_aclk / s00_axi_areset   clock, synchronous active-high reset
//   s00_axi_aw* / w* / b*           AXI4-Lite write channels (awprot ignored)
//   s00_axi_ar* / r*                AXI4-Lite read channels (arprot ignored)
//   byte_data / byte_valid          incoming song byte
//   byte_ready                      byte accepted this cycle
//   irq                             threshold interrupt (SONG_RX_IRQ_EN only)
//
// Build option: define SONG_RX_IRQ_EN to add the registered irq output
// (ENABLE & count >= THRESH & THRESH != 0). Without it, THRESH is plain
// storage and the irq port is absent.
// ============================================================================
module song_byte_receiver #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic [7:0]                      byte_data,
    input  logic                            byte_valid,
    output logic                            byte_ready
`ifdef SONG_RX_IRQ_EN
    ,
    output logic                            irq
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = 9;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_DATA    = 2'd2,
        REG_RXCOUNT = 2'd3
    } reg_sel_e;

    // Control / status state
    logic             r_enable;
    logic             r_flush;      // one-cycle pulse after a FLUSH write
    logic [7:0]       r_thresh;
    logic             r_stall;
    logic [31:0]      r_rxcount;
    logic             r_bvalid;
    logic             r_rvalid;
    logic [31:0]      r_rdata;

    // FIFO state
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_aw_hs;
    logic             w_ar_hs;
    logic             w_stall_clr;
    reg_sel_e         w_wr_sel;
    reg_sel_e         w_rd_sel;
    logic [31:0]      w_rd_value;
    logic             w_unused;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_wr_sel = reg_sel_e'(s00_axi_awaddr[3:2]);
    assign w_rd_sel = reg_sel_e'(s00_axi_araddr[3:2]);

    // AW and W are only ever taken together, and only while no B is pending.
    assign w_aw_hs = !s00_axi_areset && s00_axi_awvalid && s00_axi_wvalid && !r_bvalid;
    assign w_ar_hs = !s00_axi_areset && s00_axi_arvalid && !r_rvalid;

    // Ready is withheld during the flush cycle so no byte is accepted into a
    // FIFO that is about to be emptied.
    assign byte_ready = !s00_axi_areset && r_enable && !w_full && !r_flush;
    assign w_push     = byte_valid && byte_ready;
    assign w_pop      = w_ar_hs && (w_rd_sel == REG_DATA) && !w_empty;

    assign w_stall_clr = w_aw_hs && (w_wr_sel == REG_STATUS) &&
                         s00_axi_wstrb[2] && s00_axi_wdata[18];

    assign s00_axi_awready = w_aw_hs;
    assign s00_axi_wready  = w_aw_hs;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = w_ar_hs;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;

    // Register read mux, evaluated on pre-edge state at AR acceptance.
    always_comb begin
        // NOTE: assign a default before the case so every path drives the
        // signal; a missing path would infer a latch.
        w_rd_value = '0;
        unique case (w_rd_sel)
            REG_CTRL:    w_rd_value = {16'b0, r_thresh, 6'b0, 1'b0, r_enable};
            REG_STATUS:  w_rd_value = {13'b0, r_stall, w_full, w_empty, 7'b0, r_count};
            REG_DATA:    w_rd_value = w_empty ? 32'b0 : {1'b1, 23'b0, r_mem[r_rd_ptr]};
            REG_RXCOUNT: w_rd_value = r_rxcount;
        endcase
    end

    // AXI write side: CTRL / STATUS updates and the B response.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_enable <= 1'b0;
            r_flush  <= 1'b0;
            r_thresh <= 8'h00;
            r_stall  <= 1'b0;
            r_bvalid <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (w_aw_hs) begin
                r_bvalid <= 1'b1;
                if (w_wr_sel == REG_CTRL) begin
                    if (s00_axi_wstrb[0]) begin
                        r_enable <= s00_axi_wdata[0];
                        r_flush  <= s00_axi_wdata[1];
                    end
                    if (s00_axi_wstrb[1]) begin
                        r_thresh <= s00_axi_wdata[15:8];
                    end
                end
            end else if (s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end

            // A W1C in the same cycle as a stall condition wins; the stall
            // re-asserts on the next cycle if the condition persists.
            if (w_stall_clr) begin
                r_stall <= 1'b0;
            end else if (byte_valid && r_enable && w_full) begin
                r_stall <= 1'b1;
            end
        end
    end

    // AXI read side: rdata captured at AR acceptance, held until rready.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_value;
        end else if (s00_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing the array would buy nothing.
    always_ff @(posedge s00_axi_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= byte_data;
        end
    end

    // FIFO pointers, occupancy and the accepted-byte total.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rxcount <= 32'h0;
        end else begin
            if (w_push) begin
                r_rxcount <= r_rxcount + 32'd1;
            end
            if (r_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef SONG_RX_IRQ_EN
    logic r_irq;

    // Registered from the current count, so irq trails a count change by
    // one cycle.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_enable && (r_count >= {1'b0, r_thresh}) && (r_thresh != 8'h00);
        end
    end

    assign irq = r_irq;
`endif

    // Address LSBs, protection bits and undecoded data bits are not used.
    assign w_unused = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                        s00_axi_wdata[31:19], s00_axi_wdata[17:16],
                        s00_axi_wdata[7:2], s00_axi_wstrb[3]};

endmodule

// File: tb/tb_song_byte_receiver.sv
// ============================================================================
// tb_song_byte_receiver
//
// Directed bench for song_byte_receiver. A transaction-level model (byte
// queue plus register variables) tracks what the design must present; one
// compare process checks the DUT against it every cycle, and the directed
// sequences also check hand-computed register values.
// ============================================================================
module tb_song_byte_receiver;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
`ifdef SONG_RX_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    song_byte_receiver #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (areset),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .byte_data      (byte_data),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready)
`ifdef SONG_RX_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [7:0]  mq[$];
    bit          m_en     = 0;
    bit          m_flush  = 0;
    bit          m_stall  = 0;
    bit          m_bvalid = 0;
    bit          m_rvalid = 0;
    bit          m_irq    = 0;
    logic [7:0]  m_thresh = 8'h00;
    logic [31:0] m_rxcount = 32'h0;
    logic [31:0] m_rdata   = 32'h0;

    function automatic bit exp_byte_ready();
        return !areset && m_en && (mq.size() < DEPTH) && !m_flush;
    endfunction

    always @(posedge clk) begin : model_p
        bit          push_now, aw_now, ar_now, stall_set, stall_clr, irq_next, flush_next;
        int          cnt;
        logic [31:0] rv;
        if (areset) begin
            mq.delete();
            m_en = 0; m_flush = 0; m_stall = 0; m_bvalid = 0; m_rvalid = 0;
            m_irq = 0; m_thresh = 8'h00; m_rxcount = 32'h0; m_rdata = 32'h0;
        end else begin
            cnt       = mq.size();
            push_now  = byte_valid && exp_byte_ready();
            aw_now    = awvalid && wvalid && !m_bvalid;
            ar_now    = arvalid && !m_rvalid;
            stall_set = byte_valid && m_en && (cnt == DEPTH);
            stall_clr = aw_now && (awaddr[3:2] == 2'd1) && wstrb[2] && wdata[18];
            irq_next  = m_en && (cnt >= int'(m_thresh)) && (m_thresh != 8'h00);

            if (ar_now) begin
                rv = 32'h0;
                case (araddr[3:2])
                    2'd0: begin rv[15:8] = m_thresh; rv[0] = m_en; end
                    2'd1: begin
                        rv[8:0] = cnt[8:0];
                        rv[16]  = (cnt == 0);
                        rv[17]  = (cnt == DEPTH);
                        rv[18]  = m_stall;
                    end
                    2'd2: if (cnt != 0) rv = 32'h8000_0000 | 32'(mq[0]);
                    default: rv = m_rxcount;
                endcase
                m_rdata  = rv;
                m_rvalid = 1;
            end else if (m_rvalid && rready) begin
                m_rvalid = 0;
            end

            if (m_flush) begin
                mq.delete();
            end else begin
                if (ar_now && araddr[3:2] == 2'd2 && cnt != 0) void'(mq.pop_front());
                if (push_now) mq.push_back(byte_data);
            end
            if (push_now) m_rxcount = m_rxcount + 1;

            flush_next = 0;
            if (aw_now) begin
                m_bvalid = 1;
                if (awaddr[3:2] == 2'd0) begin
                    if (wstrb[0]) begin m_en = wdata[0]; flush_next = wdata[1]; end
                    if (wstrb[1]) m_thresh = wdata[15:8];
                end
            end else if (m_bvalid && bready) begin
                m_bvalid = 0;
            end
            m_flush = flush_next;

            if (stall_clr)      m_stall = 0;
            else if (stall_set) m_stall = 1;
            m_irq = irq_next;
        end
    end

    // Compare process: outputs settle 1 time unit after the edge; inputs
    // only change on the falling edge.
    always @(posedge clk) begin
        #1;
        check("byte_ready", byte_ready, exp_byte_ready());
        check("awready", awready, !areset && awvalid && wvalid && !m_bvalid);
        check("wready", wready, !areset && awvalid && wvalid && !m_bvalid);
        check("arready", arready, !areset && arvalid && !m_rvalid);
        check("bvalid", bvalid, m_bvalid);
        check("rvalid", rvalid, m_rvalid);
        if (m_rvalid) check("rdata", rdata, m_rdata);
        if (m_bvalid) check("bresp", bresp, 2'b00);
        if (m_rvalid) check("rresp", rresp, 2'b00);
`ifdef SONG_RX_IRQ_EN
        check("irq", irq, m_irq);
`endif
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (inputs change on the falling edge only)
    // ------------------------------------------------------------------
    task automatic wait_aw();
        bit got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            #1 got = awready;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        check("aw_accept_timeout", got, 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit got = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
        wait_aw();
        for (int n = 0; n < 50 && !got; n++) begin
            got = bvalid;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        check("b_timeout", got, 1);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit got = 0;
        data = 32'hDEAD_BEEF;
        @(negedge clk);
        araddr = addr; arvalid = 1;
        for (int n = 0; n < 50 && !got; n++) begin
            #1 got = arready;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        check("ar_accept_timeout", got, 1);
        @(negedge clk);
        arvalid = 0;
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            got = rvalid;
            if (got) data = rdata;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        check("r_timeout", got, 1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit got = 0;
        @(negedge clk);
        byte_data = b; byte_valid = 1;
        for (int n = 0; n < 50 && !got; n++) begin
            #1 got = byte_ready;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        check("push_timeout", got, 1);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        byte_valid = 0;
    endtask

    task automatic read_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(name, d, exp);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        areset = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0;
        wvalid = 0; bready = 1; araddr = 0; arprot = 0; arvalid = 0; rready = 1;
        byte_data = 0; byte_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_byte_ready", byte_ready, 0);
        areset = 0;

        // Reset state of every register
        read_check("rst_ctrl", 4'h0, 32'h0000_0000);
        read_check("rst_status", 4'h4, 32'h0001_0000);
        read_check("rst_data", 4'h8, 32'h0000_0000);
        read_check("rst_rxcount", 4'hC, 32'h0000_0000);

        // Basic push / pop
        axi_write(4'h0, 32'h1, 4'hF);
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); drop_valid();
        read_check("data_0", 4'h8, 32'h8000_0011);
        read_check("data_1", 4'h8, 32'h8000_0022);
        read_check("data_2", 4'h8, 32'h8000_0033);
        read_check("data_empty", 4'h8, 32'h0000_0000);
        read_check("status_empty", 4'h4, 32'h0001_0000);
        read_check("rxcount_3", 4'hC, 32'h0000_0003);

        // Fill to full with valid held, stall, W1C
        for (int i = 0; i < DEPTH; i++) push_byte(8'hA0 + 8'(i));
        @(negedge clk);
        byte_data = 8'hEE;
        #1 check("full_ready_low", byte_ready, 0);
        read_check("status_full_stall", 4'h4, 32'h0006_0010);
        read_check("rxcount_19", 4'hC, 32'h0000_0013);
        drop_valid();
        axi_write(4'h4, 32'h0004_0000, 4'hF);
        read_check("status_stall_clr", 4'h4, 32'h0002_0010);
        @(negedge clk);
        byte_valid = 1;
        repeat (2) @(negedge clk);
        read_check("status_stall_reset", 4'h4, 32'h0006_0010);
        drop_valid();
        axi_write(4'h0, 32'h3, 4'hF);
        axi_write(4'h4, 32'h0004_0000, 4'hF);
        read_check("status_after_flush0", 4'h4, 32'h0001_0000);

        // Flush with 5 bytes queued
        for (int i = 0; i < 5; i++) push_byte(8'h51 + 8'(i));
        drop_valid();
        read_check("status_5", 4'h4, 32'h0000_0005);
        axi_write(4'h0, 32'h3, 4'hF);
        read_check("status_flushed", 4'h4, 32'h0001_0000);
        read_check("rxcount_24", 4'hC, 32'h0000_0018);
        read_check("ctrl_flush_self_clr", 4'h0, 32'h0000_0001);

        // Concurrent push and pop
        push_byte(8'h40);
        fork
            begin
                for (int k = 1; k <= 10; k++) push_byte(8'h40 + 8'(k));
                drop_valid();
            end
            begin
                logic [31:0] d;
                for (int k = 0; k < 10; k++) begin
                    axi_read(4'h8, d);
                    check("stream_data", d, 32'h8000_0040 + 32'(k));
                end
            end
        join
        read_check("stream_last", 4'h8, 32'h8000_004A);
        read_check("stream_empty", 4'h8, 32'h0000_0000);
        read_check("rxcount_35", 4'hC, 32'h0000_0023);

        // B back-pressure: bvalid held, second write blocked
        @(negedge clk);
        bready = 0;
        axi_write(4'h0, 32'h1, 4'hF);
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'h0000_0101; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        for (int n = 0; n < 10; n++) begin
            #1;
            check("bstall_bvalid", bvalid, 1);
            check("bstall_awready", awready, 0);
            @(negedge clk);
        end
        bready = 1;
        wait_aw();
        repeat (2) @(negedge clk);
        read_check("ctrl_after_bstall", 4'h0, 32'h0000_0101);
        axi_write(4'h0, 32'h1, 4'hF);

`ifdef SONG_RX_IRQ_EN
        axi_write(4'h0, 32'h0401, 4'hF);
        for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i));
        @(negedge clk);
        byte_valid = 0;
        #1 check("irq_before", irq, 0);
        @(negedge clk);
        #1 check("irq_rise", irq, 1);
        read_check("irq_data", 4'h8, 32'h8000_0061);
        @(negedge clk);
        #1 check("irq_fall", irq, 0);
        push_byte(8'h65);
        drop_valid();
        @(negedge clk);
        #1 check("irq_rise2", irq, 1);
        axi_write(4'h0, 32'h0001, 4'hF);
        @(negedge clk);
        #1 check("irq_thresh0", irq, 0);
        push_byte(8'h66); push_byte(8'h67); drop_valid();
        repeat (3) @(negedge clk);
        #1 check("irq_thresh0_hold", irq, 0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
